// File: rtl/stage1_pkg.sv
`default_nettype none
// ============================================================================
// stage1_pkg : shared types for the Stage1 max-search controller
// Revision   : 1.0
// ============================================================================
package stage1_pkg;

  localparam int IDX_W = 4;
  localparam int CNT_W = 5;
  // Candidate value width used throughout the Stage1 datapath
  localparam int VAL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } max_state_e;

  typedef struct packed {
    logic [VAL_W-1:0] value;
    logic [IDX_W-1:0] idx;
    logic             align;
  } max_acc_t;

endpackage
`default_nettype wire

// File: rtl/max2_with_index.sv
`default_nettype none
// ============================================================================
// max2_with_index : two-way max with alignment tie-break, A kept on full tie
// Revision        : 1.0
// ============================================================================
module max2_with_index #(
  parameter int WIDTH = 2,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] i_a_value,
  input  logic [IDX_W-1:0] i_a_idx,
  input  logic             i_a_align,
  input  logic [WIDTH-1:0] i_b_value,
  input  logic [IDX_W-1:0] i_b_idx,
  input  logic             i_b_align,
  output logic [WIDTH-1:0] o_y_value,
  output logic [IDX_W-1:0] o_y_idx,
  output logic             o_y_align
);

  logic w_b_wins;

  assign w_b_wins = (i_b_value > i_a_value) ||
                    ((i_b_value == i_a_value) && i_b_align && !i_a_align);

  assign o_y_value = w_b_wins ? i_b_value : i_a_value;
  assign o_y_idx   = w_b_wins ? i_b_idx   : i_a_idx;
  assign o_y_align = w_b_wins ? i_b_align : i_a_align;

endmodule
`default_nettype wire

// File: rtl/max_search_ctrl.sv
`default_nettype none
// ============================================================================
// max_search_ctrl : streams a block of candidates through one shared max2
//                   comparator and emits the winning value/index per block
// Revision        : 1.0
// ============================================================================
module max_search_ctrl
  import stage1_pkg::*;
#(
  parameter int WIDTH    = VAL_W,
  parameter int NUM_CAND = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cand_valid,
  output logic             o_cand_ready,
  input  logic [WIDTH-1:0] i_cand_value,
  input  logic             i_cand_align,
  input  logic             i_cand_last,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_value,
  output logic [IDX_W-1:0] o_res_idx,
  output logic             o_res_align,
  output logic [CNT_W-1:0] o_res_count,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] C_LAST_POS = CNT_W'(NUM_CAND - 1);

  generate
    if (WIDTH != VAL_W || NUM_CAND < 1 || NUM_CAND > 16) begin : g_param_check
      $error("max_search_ctrl: unsupported WIDTH/NUM_CAND");
    end
  endgenerate

  max_state_e       state_q, state_d;
  max_acc_t         acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             res_hs;
  logic             beat_final;
  logic [CNT_W-1:0] beat_pos;
  logic [WIDTH-1:0] cmp_value;
  logic [IDX_W-1:0] cmp_idx;
  logic             cmp_align;

  max2_with_index #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_cmp (
    .i_a_value (acc_q.value),
    .i_a_idx   (acc_q.idx),
    .i_a_align (acc_q.align),
    .i_b_value (i_cand_value),
    .i_b_idx   (cnt_q[IDX_W-1:0]),
    .i_b_align (i_cand_align),
    .o_y_value (cmp_value),
    .o_y_idx   (cmp_idx),
    .o_y_align (cmp_align)
  );

  assign o_cand_ready = (state_q != DONE);
  assign o_res_valid  = (state_q == DONE);
  assign o_busy       = (state_q != IDLE);
  assign accept       = i_cand_valid && o_cand_ready;
  assign res_hs       = o_res_valid && i_res_ready;

  // In IDLE the counter still holds the previous block's count, so the
  // incoming beat's position is taken as 0 for the forced-end test.
  assign beat_pos   = (state_q == IDLE) ? '0 : cnt_q;
  assign beat_final = i_cand_last || (beat_pos == C_LAST_POS);

  assign o_res_value = acc_q.value;
  assign o_res_idx   = acc_q.idx;
  assign o_res_align = acc_q.align;
  assign o_res_count = cnt_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d.value = i_cand_value;
          acc_d.idx   = '0;
          acc_d.align = i_cand_align;
          cnt_d       = CNT_W'(1);
          state_d     = beat_final ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d.value = cmp_value;
          acc_d.idx   = cmp_idx;
          acc_d.align = cmp_align;
          cnt_d       = cnt_q + CNT_W'(1);
          if (beat_final) state_d = DONE;
        end
      end
      DONE: begin
        if (res_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_max_search_ctrl.sv
`default_nettype none
// ============================================================================
// tb_max_search_ctrl : directed blocks, expected results queued, monitor checks
// Revision           : 1.0
// ============================================================================
module tb_max_search_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cand_valid = 1'b0;
  logic       cand_ready;
  logic [1:0] cand_value = '0;
  logic       cand_align = 1'b0;
  logic       cand_last = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [1:0] res_value;
  logic [3:0] res_idx;
  logic       res_align;
  logic [4:0] res_count;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int value;
    int idx;
    int align;
    int count;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  max_search_ctrl #(.WIDTH(2), .NUM_CAND(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cand_valid (cand_valid),
    .o_cand_ready (cand_ready),
    .i_cand_value (cand_value),
    .i_cand_align (cand_align),
    .i_cand_last  (cand_last),
    .o_res_valid  (res_valid),
    .i_res_ready  (res_ready),
    .o_res_value  (res_value),
    .o_res_idx    (res_idx),
    .o_res_align  (res_align),
    .o_res_count  (res_count),
    .o_busy       (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int v, input int i, input int a, input int c);
    exp_t e;
    e.value = v; e.idx = i; e.align = a; e.count = c;
    exp_q.push_back(e);
  endtask

  // Present one beat and hold it until accepted; returns at posedge+1.
  task automatic beat(input logic [1:0] v, input logic a, input logic l);
    int n;
    n = 0;
    cand_valid = 1'b1;
    cand_value = v;
    cand_align = a;
    cand_last  = l;
    @(negedge clk);
    while (!cand_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check("beat_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    cand_valid = 1'b0;
    cand_last  = 1'b0;
  endtask

  // Monitor: every result handshake pops one expected entry.
  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_value", int'(res_value), e.value);
        check("res_idx",   int'(res_idx),   e.idx);
        check("res_align", int'(res_align), e.align);
        check("res_count", int'(res_count), e.count);
      end
    end
  end

  initial begin
    logic [1:0] hv;
    logic [3:0] hi;
    logic       ha;
    logic [4:0] hc;
    int         n;

    #2;
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cand_ready", int'(cand_ready), 1);
    check("rst_res_count", int'(res_count), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Block 1: [1,3,2,0] -> value 3 idx 1
    push(3, 1, 0, 4);
    beat(2'd1, 1'b0, 1'b0);
    check("accum_busy", int'(busy), 1);
    beat(2'd3, 1'b0, 1'b0);
    beat(2'd2, 1'b0, 1'b0);
    beat(2'd0, 1'b0, 1'b1);
    check("b1_latency_valid", int'(res_valid), 1);
    @(posedge clk); #1;

    // Block 2: aligned wins tie, later equal-aligned does not replace
    push(2, 1, 1, 3);
    beat(2'd2, 1'b0, 1'b0);
    beat(2'd2, 1'b1, 1'b0);
    beat(2'd2, 1'b1, 1'b1);
    @(posedge clk); #1;

    // Block 3: all equal unaligned -> first kept
    push(1, 0, 0, 4);
    for (int i = 0; i < 4; i++) beat(2'd1, 1'b0, (i == 3));
    @(posedge clk); #1;

    // Block 4: single beat
    push(2, 0, 1, 1);
    beat(2'd2, 1'b1, 1'b1);
    check("single_latency_valid", int'(res_valid), 1);
    @(posedge clk); #1;

    // Block 5: 16 beats without last -> forced end; 17th beat held off
    push(3, 15, 0, 16);
    push(2, 0, 0, 1);
    res_ready = 1'b0;
    for (int i = 0; i < 16; i++) beat((i == 15) ? 2'd3 : 2'd1, 1'b0, 1'b0);
    check("forced_end_valid", int'(res_valid), 1);
    cand_valid = 1'b1; cand_value = 2'd2; cand_align = 1'b0; cand_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("held_off_ready", int'(cand_ready), 0);
    end
    res_ready = 1'b1;
    beat(2'd2, 1'b0, 1'b1);
    @(posedge clk); #1;

    // Block 6: result back-pressure for 5 cycles
    push(3, 2, 1, 3);
    res_ready = 1'b0;
    beat(2'd1, 1'b0, 1'b0);
    beat(2'd0, 1'b1, 1'b0);
    beat(2'd3, 1'b1, 1'b1);
    hv = res_value; hi = res_idx; ha = res_align; hc = res_count;
    repeat (5) begin
      @(negedge clk);
      check("stall_value", int'(res_value), int'(hv));
      check("stall_idx", int'(res_idx), int'(hi));
      check("stall_align", int'(res_align), int'(ha));
      check("stall_count", int'(res_count), int'(hc));
      check("stall_cand_ready", int'(cand_ready), 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_cand_ready", int'(cand_ready), 1);

    // Block 7: asynchronous reset mid-block discards it
    beat(2'd3, 1'b1, 1'b0);
    beat(2'd2, 1'b0, 1'b0);
    beat(2'd1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_res_valid", int'(res_valid), 0);
    check("arst_cand_ready", int'(cand_ready), 1);
    check("arst_res_value", int'(res_value), 0);
    check("arst_res_idx", int'(res_idx), 0);
    check("arst_res_count", int'(res_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(2, 1, 0, 2);
    beat(2'd0, 1'b0, 1'b0);
    beat(2'd2, 1'b0, 1'b1);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/max_search_ctrl.md
Name: max_search_ctrl

Overview:
- Sequences one shared `max2_with_index` comparator across a block of up to NUM_CAND candidates arriving one per cycle on a valid/ready stream.
- Keeps a running best (value, index, alignment flag) and emits one result per block on a second valid/ready stream.
- Sits in the Stage1 compression datapath, between the candidate generator and the encoder that consumes the winning index.

Parameters:
- WIDTH, 2, bit width of each candidate value.
- NUM_CAND, 16, maximum candidates per block; legal range 1..16, because the index is 4 bits.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_cand_valid  input  1  candidate beat valid.
- o_cand_ready  output  1  controller can accept a candidate.
- i_cand_value  input  WIDTH  candidate value.
- i_cand_align  input  1  candidate alignment flag.
- i_cand_last  input  1  final beat of the block.
- o_res_valid  output  1  result valid.
- i_res_ready  input  1  consumer accepts the result.
- o_res_value  output  WIDTH  winning value.
- o_res_idx  output  4  winning candidate index (beat position, 0-based).
- o_res_align  output  1  alignment flag of the winner.
- o_res_count  output  5  number of beats in the block (1..NUM_CAND).
- o_busy  output  1  block in progress or result pending.

Behaviour:
- One clock, i_clk. Reset is asynchronous and active-low, on i_rst_n.
- Reset state:
  - state = IDLE; accumulator, beat counter and all result registers = 0.
  - o_res_valid = 0, o_busy = 0.
  - o_cand_ready = 1 (decoded from state IDLE/ACCUM).
- A beat is accepted when i_cand_valid & o_cand_ready. A result handshake occurs when o_res_valid & i_res_ready.
- States:
  - IDLE: o_cand_ready = 1.
    - On an accepted beat, load the accumulator directly: value, idx = 0, align. No comparison.
    - Beat counter = 1.
    - If the beat is final, go to DONE; otherwise go to ACCUM.
  - ACCUM: o_cand_ready = 1, one beat per cycle.
    - Each accepted beat drives the comparator: A = accumulator, B = candidate with idxB = beat counter[3:0].
    - The comparator output is registered into the accumulator at the same clock edge.
    - Beat counter increments on each accepted beat.
    - On the final beat, go to DONE.
    - No accepted beat: hold all state.
  - DONE: o_cand_ready = 0, o_res_valid = 1, and the result outputs equal the accumulator and counter.
    - On a result handshake, go to IDLE.
    - The next beat can be accepted from the following cycle, so there is a one-cycle gap between blocks.
- A beat is final when i_cand_last = 1, or when the beat counter before increment equals NUM_CAND-1 (forced termination).
  - After a forced end, later beats start a new block; the counter never wraps inside a block.
- Selection rules (comparator semantics, must hold):
  - Strictly greater value wins.
  - On equal values, the aligned entry beats the unaligned one.
  - On equal values and equal alignment, the accumulator (earlier index) is kept.
- Latency: if the final beat is accepted in cycle N, o_res_valid = 1 in cycle N+1. Throughput is one candidate per cycle.
- Result outputs are registered and stay stable while o_res_valid = 1 and i_res_ready = 0.
- o_busy = 1 in ACCUM and DONE.
- i_cand_value and i_cand_align are ignored when there is no accepted beat.
- Reset during ACCUM or DONE discards the partial block and any pending result. The next accepted beat gets idx 0.
- o_res_count is 5 bits so that a count of 16 is representable.

Decomposition:
- Shared package `stage1_pkg`:
  - typedef `max_state_e` {IDLE, ACCUM, DONE}.
  - localparam IDX_W = 4 and CNT_W = 5.
  - typedef struct `max_acc_t` {value, idx, align}.
- One sub-module instance: `max2_with_index`, used as the comparator with WIDTH passed through. The controller does not re-implement comparison or tie-break logic.

Test Plan:
- WIDTH=2, beats values [1,3,2,0], all align 0, last on beat 3 -> o_res_valid in the cycle after beat 3; value 3, idx 1, align 0, count 4.
- Values [2,2,2], align [0,1,1], last on beat 2 -> idx 1, align 1, count 3. Checks that aligned wins a tie and that an equal-aligned later beat does not replace it.
- Values [1,1,1,1], all unaligned -> idx 0. Single beat value 2, align 1, last -> idx 0, count 1, result one cycle later.
- 16 beats with i_cand_last = 0, value 3 only at beat 15, others 1 -> forced end, idx 15, count 16. A 17th beat presented is held off (o_cand_ready = 0) until the result handshake, then becomes idx 0 of the next block.
- i_res_ready held low 5 cycles in DONE -> o_res_value, o_res_idx, o_res_align and o_res_count stable; o_cand_ready = 0. One cycle after the handshake, o_cand_ready = 1.
- Assert i_rst_n = 0 asynchronously after 3 beats of a block -> all outputs 0 immediately, o_cand_ready = 1. A new block [0,2], last -> idx 1, count 2.
